main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have no parameters; state encoding comes from main_fsm_pkg.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Op  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-005 SHALL have port Funct  input  6  Funct[5]=I (immediate), Funct[0]=S/L (load when Op=01).
REQ-006 SHALL have port MemReady  input  1  memory-done handshake; used only when MAIN_FSM_MEMWAIT_EN is defined.
REQ-007 SHALL have port IRWrite  output  1  instruction-register load enable.
REQ-008 SHALL have port AdrSrc  output  1  memory address select: 0 PC, 1 ALU result.
REQ-009 SHALL have port ALUSrcA  output  2  ALU A select.
REQ-010 SHALL have port ALUSrcB  output  2  ALU B select.
REQ-011 SHALL have port ResultSrc  output  2  result-bus select.
REQ-012 SHALL have port ALUOp  output  1  1 = ALU decoder uses Funct; 0 = force ADD.
REQ-013 SHALL have port NextPC  output  1  unconditional PC update.
REQ-014 SHALL have ports RegW, MemW, Branch  output  1 each  raw write/branch requests, consumed downstream by the condition logic that gates them with CondEx.
REQ-015 SHALL have port Illegal  output  1  one-cycle pulse while in UNKNOWN.

Function
REQ-016 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
REQ-017 FETCH SHALL drive IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0, and go to DECODE.
REQ-018 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=10, and go to: MEMADR if Op=01; EXECUTER if Op=00 and Funct[5]=0; EXECUTEI if Op=00 and Funct[5]=1; BRANCH if Op=10; UNKNOWN if Op=11.
REQ-019 MEMADR SHALL drive ALUSrcA=00, ALUSrcB=01, ALUOp=0, and go to MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-020 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00, and go to MEMWB.
REQ-021 MEMWB SHALL drive ResultSrc=01, RegW=1, and go to FETCH.
REQ-022 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemW=1, and go to FETCH.
REQ-023 EXECUTER SHALL drive ALUSrcA=00, ALUSrcB=00, ALUOp=1, and go to ALUWB.
REQ-024 EXECUTEI SHALL drive ALUSrcA=00, ALUSrcB=01, ALUOp=1, and go to ALUWB.
REQ-025 ALUWB SHALL drive ResultSrc=00, RegW=1, and go to FETCH.
REQ-026 BRANCH SHALL drive ALUSrcA=00, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1, and go to FETCH.
REQ-027 UNKNOWN SHALL drive Illegal=1 and all enables 0, and go to FETCH.
REQ-028 Every output not listed for a state SHALL be 0; there are no don't-cares.
REQ-029 Outputs SHALL depend on state only (no Op/Funct feed-through); next state SHALL be registered on the clk rising edge.
REQ-030 Instruction latencies SHALL be (without wait states): load 5 cycles, store 4, data-processing 4, branch 3, illegal 3.

Reset
REQ-031 reset low SHALL force state FETCH immediately, independent of clk.
REQ-032 While reset is low, IRWrite, NextPC, RegW, MemW, Branch and Illegal SHALL be 0; the other outputs SHALL hold their FETCH values.
REQ-033 After reset rises, the first clk edge SHALL execute FETCH; a reset asserted mid-instruction SHALL abandon that instruction without issuing RegW or MemW.

Configuration
REQ-034 With MAIN_FSM_MEMWAIT_EN defined, FETCH, MEMREAD and MEMWRITE SHALL hold their state and outputs until MemReady=1, then advance on that edge; IRWrite, NextPC and MemW SHALL be asserted only in the MemReady=1 cycle.
REQ-035 Without MAIN_FSM_MEMWAIT_EN, MemReady SHALL be ignored and every state SHALL last exactly one cycle.

Structure
REQ-036 main_fsm_pkg SHALL hold the statetype enum (4-bit), Op encodings (OP_DP, OP_MEM, OP_BR) and the ALUSrcA/ALUSrcB/ResultSrc select constants.
REQ-037 State-to-control-word decoding SHALL be a sub-module main_fsm_outdec (combinational); main_fsm holds the state register and next-state logic.

Verification
REQ-038 Reset low mid-MEMWRITE, then released -> MemW drops to 0 at once, state=FETCH, and the first cycle after release has IRWrite=1.
REQ-039 Op=01, Funct=000001 (LDR) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegW=1 only in cycle 5 with ResultSrc=01.
REQ-040 Op=00, Funct=100000 (ADD immediate) -> EXECUTEI with ALUSrcB=01 and ALUOp=1, then ALUWB with RegW=1; 4 cycles total.
REQ-041 Op=10 -> BRANCH in cycle 3 with Branch=1, ALUSrcB=01, NextPC=0; back to FETCH in cycle 4.
REQ-042 Op=11 -> Illegal=1 for exactly 1 cycle and RegW=MemW=0 throughout, then FETCH.
REQ-043 MAIN_FSM_MEMWAIT_EN defined, STR, MemReady held low 3 cycles in MEMWRITE -> state holds 3 cycles with MemW=0, MemW=1 on the MemReady=1 cycle, then FETCH.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// Shared types and encodings for the multicycle control FSM (main_fsm).
// The optional memory wait states are enabled by defining MAIN_FSM_MEMWAIT_EN.
package main_fsm_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned SEL_W   = 2;

    localparam int unsigned FUNCT_I_BIT = 5;
    localparam int unsigned FUNCT_L_BIT = 0;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } statetype;

    localparam logic [OP_W-1:0] OP_DP  = 2'b00;
    localparam logic [OP_W-1:0] OP_MEM = 2'b01;
    localparam logic [OP_W-1:0] OP_BR  = 2'b10;
    localparam logic [OP_W-1:0] OP_ILL = 2'b11;

    localparam logic [SEL_W-1:0] SRCA_REG   = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;
    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic             ir_write;
        logic             adr_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] result_src;
        logic             alu_op;
        logic             next_pc;
        logic             reg_w;
        logic             mem_w;
        logic             branch;
        logic             illegal;
    } ctrl_t;

    // Enables drop during reset; memory-side strobes fire only on the ready cycle.
    function automatic ctrl_t mask_enables(ctrl_t c, logic en, logic mem_ready);
        ctrl_t m;
        m          = c;
        m.ir_write = c.ir_write & en & mem_ready;
        m.next_pc  = c.next_pc  & en & mem_ready;
        m.mem_w    = c.mem_w    & en & mem_ready;
        m.reg_w    = c.reg_w    & en;
        m.branch   = c.branch   & en;
        m.illegal  = c.illegal  & en;
        return m;
    endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// State-to-control-word decoder for main_fsm (combinational, Moore outputs).
module main_fsm_outdec
    import main_fsm_pkg::*;
(
    input  statetype i_state,
    input  logic     i_en,
    input  logic     i_mem_ready,
    output ctrl_t    o_ctrl_c
);

    ctrl_t w_raw;

    always_comb begin
        w_raw = '0;
        case (i_state)
            FETCH: begin
                w_raw.ir_write   = 1'b1;
                w_raw.next_pc    = 1'b1;
                w_raw.adr_src    = 1'b0;
                w_raw.alu_src_a  = SRCA_PC;
                w_raw.alu_src_b  = SRCB_FOUR;
                w_raw.result_src = RES_ALU;
                w_raw.alu_op     = 1'b0;
            end
            DECODE: begin
                w_raw.alu_src_a  = SRCA_PC;
                w_raw.alu_src_b  = SRCB_FOUR;
                w_raw.result_src = RES_ALU;
            end
            MEMADR: begin
                w_raw.alu_src_a  = SRCA_REG;
                w_raw.alu_src_b  = SRCB_IMM;
                w_raw.alu_op     = 1'b0;
            end
            MEMREAD: begin
                w_raw.adr_src    = 1'b1;
                w_raw.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                w_raw.result_src = RES_DATA;
                w_raw.reg_w      = 1'b1;
            end
            MEMWRITE: begin
                w_raw.adr_src    = 1'b1;
                w_raw.result_src = RES_ALUOUT;
                w_raw.mem_w      = 1'b1;
            end
            EXECUTER: begin
                w_raw.alu_src_a  = SRCA_REG;
                w_raw.alu_src_b  = SRCB_REG;
                w_raw.alu_op     = 1'b1;
            end
            EXECUTEI: begin
                w_raw.alu_src_a  = SRCA_REG;
                w_raw.alu_src_b  = SRCB_IMM;
                w_raw.alu_op     = 1'b1;
            end
            ALUWB: begin
                w_raw.result_src = RES_ALUOUT;
                w_raw.reg_w      = 1'b1;
            end
            BRANCH: begin
                w_raw.alu_src_a  = SRCA_REG;
                w_raw.alu_src_b  = SRCB_IMM;
                w_raw.alu_op     = 1'b0;
                w_raw.result_src = RES_ALU;
                w_raw.branch     = 1'b1;
            end
            UNKNOWN: begin
                w_raw.illegal    = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_ctrl_c = mask_enables(w_raw, i_en, i_mem_ready);

endmodule

// File: rtl/main_fsm.sv
// Multicycle processor main control FSM: state register, next-state logic, decoder.
// Define MAIN_FSM_MEMWAIT_EN to stall FETCH/MEMREAD/MEMWRITE on MemReady.
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    Op,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [SEL_W-1:0]   ALUSrcA,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic [SEL_W-1:0]   ResultSrc,
    output logic               ALUOp,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               Illegal
);

    statetype r_state;
    ctrl_t    w_ctrl;
    logic     w_mem_ready;
    logic     w_unused_funct;

`ifdef MAIN_FSM_MEMWAIT_EN
    assign w_mem_ready = MemReady;
`else
    logic w_unused_mem_ready;
    assign w_mem_ready        = 1'b1;
    assign w_unused_mem_ready = MemReady;
`endif

    // Only the I and S/L bits of Funct steer the sequence.
    assign w_unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:    if (w_mem_ready) r_state <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_MEM:  r_state <= MEMADR;
                        OP_DP:   r_state <= Funct[FUNCT_I_BIT] ? EXECUTEI : EXECUTER;
                        OP_BR:   r_state <= BRANCH;
                        default: r_state <= UNKNOWN;
                    endcase
                end
                MEMADR:   r_state <= Funct[FUNCT_L_BIT] ? MEMREAD : MEMWRITE;
                MEMREAD:  if (w_mem_ready) r_state <= MEMWB;
                MEMWB:    r_state <= FETCH;
                MEMWRITE: if (w_mem_ready) r_state <= FETCH;
                EXECUTER: r_state <= ALUWB;
                EXECUTEI: r_state <= ALUWB;
                ALUWB:    r_state <= FETCH;
                BRANCH:   r_state <= FETCH;
                UNKNOWN:  r_state <= FETCH;
                default:  r_state <= FETCH;
            endcase
        end
    end

    main_fsm_outdec u_outdec (
        .i_state     (r_state),
        .i_en        (reset),
        .i_mem_ready (w_mem_ready),
        .o_ctrl_c    (w_ctrl)
    );

    assign IRWrite   = w_ctrl.ir_write;
    assign AdrSrc    = w_ctrl.adr_src;
    assign ALUSrcA   = w_ctrl.alu_src_a;
    assign ALUSrcB   = w_ctrl.alu_src_b;
    assign ResultSrc = w_ctrl.result_src;
    assign ALUOp     = w_ctrl.alu_op;
    assign NextPC    = w_ctrl.next_pc;
    assign RegW      = w_ctrl.reg_w;
    assign MemW      = w_ctrl.mem_w;
    assign Branch    = w_ctrl.branch;
    assign Illegal   = w_ctrl.illegal;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed latency table, reset corners, random vs model.
module tb_main_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef MAIN_FSM_MEMWAIT_EN
    localparam bit MEMWAIT = 1'b1;
`else
    localparam bit MEMWAIT = 1'b0;
`endif

    typedef logic [13:0] word_t;
    typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                      P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_UNK} ph_t;

    typedef struct packed {
        bit [1:0] op;
        bit [5:0] funct;
        int       len;
        int       regw_at;
        int       memw_at;
        int       br_at;
        int       ill_at;
    } vec_t;

    ph_t  plan[$];
    vec_t vecs[7];

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .MemReady  (MemReady),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .Illegal   (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t mk(bit irw, bit adr, bit [1:0] a, bit [1:0] b, bit [1:0] r,
                                 bit aop, bit npc, bit rw, bit mw, bit br, bit ill);
        return {irw, adr, a, b, r, aop, npc, rw, mw, br, ill};
    endfunction

    // Control word each step of an instruction must show, from the state table.
    function automatic word_t exp_word(ph_t ph, bit rdy);
        word_t w;
        case (ph)
            P_FETCH:    w = mk(1, 0, 2'b01, 2'b10, 2'b10, 0, 1, 0, 0, 0, 0);
            P_DECODE:   w = mk(0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
            P_MEMADR:   w = mk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
            P_MEMREAD:  w = mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
            P_MEMWB:    w = mk(0, 0, 2'b00, 2'b00, 2'b01, 0, 0, 1, 0, 0, 0);
            P_MEMWRITE: w = mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
            P_EXECR:    w = mk(0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
            P_EXECI:    w = mk(0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0);
            P_ALUWB:    w = mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0);
            P_BRANCH:   w = mk(0, 0, 2'b00, 2'b01, 2'b10, 0, 0, 0, 0, 1, 0);
            default:    w = mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1);
        endcase
        if (MEMWAIT && !rdy) begin
            if (ph == P_FETCH) begin
                w[13] = 1'b0;
                w[4]  = 1'b0;
            end
            if (ph == P_MEMWRITE) w[2] = 1'b0;
        end
        return w;
    endfunction

    function automatic word_t dut_word();
        return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal};
    endfunction

    function automatic bit waitable(ph_t ph);
        return (ph == P_FETCH) || (ph == P_MEMREAD) || (ph == P_MEMWRITE);
    endfunction

    task automatic check_word(input string name, input word_t exp);
        word_t act;
        act = dut_word();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sequence of steps an instruction walks through.
    task automatic build_plan(input bit [1:0] op, input bit [5:0] funct);
        plan.delete();
        plan.push_back(P_FETCH);
        plan.push_back(P_DECODE);
        case (op)
            2'b01: begin
                plan.push_back(P_MEMADR);
                if (funct[0]) begin
                    plan.push_back(P_MEMREAD);
                    plan.push_back(P_MEMWB);
                end else begin
                    plan.push_back(P_MEMWRITE);
                end
            end
            2'b00: begin
                plan.push_back(funct[5] ? P_EXECI : P_EXECR);
                plan.push_back(P_ALUWB);
            end
            2'b10:   plan.push_back(P_BRANCH);
            default: plan.push_back(P_UNK);
        endcase
    endtask

    task automatic run_random_instr(input bit [1:0] op, input bit [5:0] funct);
        int waits;
        bit rdy;
        build_plan(op, funct);
        Op    = op;
        Funct = funct;
        foreach (plan[i]) begin
            waits = 0;
            do begin
                rdy      = ($urandom_range(0, 3) != 0) || (waits >= 6);
                MemReady = rdy;
                #1;
                check_word($sformatf("rand op=%0d funct=%0h step=%s", op, funct, plan[i].name()),
                           exp_word(plan[i], rdy));
                @(posedge clk);
                #1;
                waits++;
            end while (MEMWAIT && waitable(plan[i]) && !rdy);
        end
    endtask

    // Measure one instruction: length and the cycle in which each strobe appears.
    task automatic run_vec(input int k, input bit rdy);
        int len, rw, mw, br, il;
        len = 0; rw = 0; mw = 0; br = 0; il = 0;
        Op       = vecs[k].op;
        Funct    = vecs[k].funct;
        MemReady = rdy;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (c > 1 && IRWrite) begin
                len = c - 1;
                break;
            end
            if (RegW)    rw = (rw == 0) ? c : -1;
            if (MemW)    mw = (mw == 0) ? c : -1;
            if (Branch)  br = (br == 0) ? c : -1;
            if (Illegal) il = (il == 0) ? c : -1;
            @(posedge clk);
            #1;
        end
        check_int($sformatf("vec%0d length", k), len, vecs[k].len);
        check_int($sformatf("vec%0d RegW cycle", k), rw, vecs[k].regw_at);
        check_int($sformatf("vec%0d MemW cycle", k), mw, vecs[k].memw_at);
        check_int($sformatf("vec%0d Branch cycle", k), br, vecs[k].br_at);
        check_int($sformatf("vec%0d Illegal cycle", k), il, vecs[k].ill_at);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w_rst;
        w_rst = mk(0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);

        //            op     funct      len rw mw br il
        vecs[0] = '{2'b01, 6'b000001, 5, 5, 0, 0, 0};   // LDR
        vecs[1] = '{2'b01, 6'b000000, 4, 0, 4, 0, 0};   // STR
        vecs[2] = '{2'b00, 6'b000000, 4, 4, 0, 0, 0};   // ADD reg
        vecs[3] = '{2'b00, 6'b100000, 4, 4, 0, 0, 0};   // ADD imm
        vecs[4] = '{2'b10, 6'b000000, 3, 0, 0, 3, 0};   // B
        vecs[5] = '{2'b11, 6'b101010, 3, 0, 0, 0, 3};   // illegal
        vecs[6] = '{2'b01, 6'b111111, 5, 5, 0, 0, 0};   // load, other bits set

        reset    = 1'b0;
        Op       = 2'b00;
        Funct    = 6'b0;
        MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_word("reset hold", w_rst);
        @(posedge clk);
        #1;
        check_word("reset hold after edge", w_rst);
        reset = 1'b1;
        #1;
        check_word("first fetch", exp_word(P_FETCH, 1'b1));

        for (int k = 0; k < 7; k++) run_vec(k, 1'b1);

        // Reset dropped in the middle of a store.
        Op    = 2'b01;
        Funct = 6'b000000;
        MemReady = 1'b1;
        #1;
        repeat (3) @(posedge clk);
        #1;
        check_int("MemW in MEMWRITE", int'(MemW), 1);
        reset = 1'b0;
        #1;
        check_int("MemW at reset", int'(MemW), 0);
        check_word("reset mid-store", w_rst);
        @(posedge clk);
        #1;
        check_word("reset mid-store held", w_rst);
        reset = 1'b1;
        Op    = 2'b10;
        #1;
        check_word("fetch after release", exp_word(P_FETCH, 1'b1));
        @(posedge clk);
        #1;
        check_word("decode after release", exp_word(P_DECODE, 1'b1));
        @(posedge clk);
        #1;
        check_word("branch after release", exp_word(P_BRANCH, 1'b1));
        @(posedge clk);
        #1;
        check_word("fetch after branch", exp_word(P_FETCH, 1'b1));

`ifdef MAIN_FSM_MEMWAIT_EN
        // Fetch stall, then a store held three cycles in MEMWRITE.
        Op       = 2'b01;
        Funct    = 6'b000000;
        MemReady = 1'b0;
        #1;
        check_word("fetch stalled", exp_word(P_FETCH, 1'b0));
        @(posedge clk);
        #1;
        check_word("fetch still stalled", exp_word(P_FETCH, 1'b0));
        MemReady = 1'b1;
        #1;
        check_word("fetch ready", exp_word(P_FETCH, 1'b1));
        repeat (3) @(posedge clk);
        #1;
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_word($sformatf("memwrite wait %0d", i), exp_word(P_MEMWRITE, 1'b0));
            check_int($sformatf("MemW during wait %0d", i), int'(MemW), 0);
            @(posedge clk);
            #1;
        end
        MemReady = 1'b1;
        #1;
        check_int("MemW on ready", int'(MemW), 1);
        @(posedge clk);
        #1;
        check_word("fetch after store wait", exp_word(P_FETCH, 1'b1));
`else
        // MemReady low must not stretch anything.
        run_vec(2, 1'b0);
        run_vec(1, 1'b0);
`endif

        for (int n = 0; n < 300; n++) begin
            run_random_instr(2'($urandom_range(0, 3)), 6'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
